spi_master_arbiter: RTL
=======================

// Module: spi_master_arbiter
// PURPOSE
//  Shares one SPI master port between NREQ requesters, each owning one slave chip-select.
//  Round-robin arbitration, frame serialisation (mode 0, MSB first), per-frame done.
//  Sits between the system-side command sources and the SPI pins.
// PARAMETERS
//  NREQ     4   number of requesters / chip selects (2..8)
//  DW       16  bits per frame
//  CLK_DIV  2   clk cycles per spi_clk half-period (>=1)
//  GAP      2   clk cycles all cs_l held high between frames (>=1)
// PORTS
//  clk       in   1        system clock; all logic on posedge
//  reset     in   1        asynchronous, active-high reset
//  req       in   NREQ     level request per requester; hold until gnt
//  din       in   NREQ*DW  frame data; requester i uses din[i*DW +: DW]
//  gnt       out  NREQ     one-hot, 1-cycle pulse: din of winner captured
//  done      out  NREQ     one-hot, 1-cycle pulse: frame of that requester complete
//  busy      out  1        high from gnt cycle through end of GAP
//  spi_cs_l  out  NREQ     active-low chip selects, at most one low
//  spi_clk   out  1        SPI clock, idles low
//  spi_data  out  1        MOSI
//  spi_miso  in   1        MISO (used only with SPI_RX_EN)
//  rx_data   out  DW       received frame (only with SPI_RX_EN)
// BEHAVIOUR
//  Reset: gnt=0, done=0, busy=0, spi_cs_l=all 1, spi_clk=0, spi_data=0, rx_data=0,
//   state=IDLE, rr pointer=NREQ-1 (requester 0 has top priority first).
//  States: IDLE -> LO -> HI -> (LO | END) ; END -> GAP -> IDLE.
//  IDLE: if |req, winner = first set req scanning ptr+1, ptr+2, ... (mod NREQ).
//   Next edge: gnt[w]=1, shreg<=din[w], spi_cs_l[w]=0, spi_data=din[w][DW-1],
//   busy=1, ptr<=w, bitcnt<=DW, state LO. req seen low in IDLE is ignored.
//  LO: spi_clk=0 for CLK_DIV cycles, then spi_clk<=1, state HI.
//  HI: spi_clk=1 for CLK_DIV cycles; slave samples on rising edge.
//   At end: spi_clk<=0, bitcnt-1; if bitcnt-1 != 0 shift left, spi_data<=next bit, LO;
//   else state END.
//  END (1 cycle): spi_cs_l all 1, spi_data<=0, done[w]=1 (pulse), state GAP.
//  GAP: GAP cycles idle, then IDLE; busy drops entering IDLE.
//  cs_l low duration = 2*CLK_DIV*DW clk cycles; gnt-to-done = 2*CLK_DIV*DW+1 cycles.
//  Back-to-back: a req held through GAP is arbitrated on first IDLE cycle.
//  Reqs arriving mid-frame wait; din sampled only at gnt; later din changes ignored.
//  Pointer update only on gnt; single requester may be served repeatedly.
//  Reset mid-frame: all outputs to reset values immediately; no done issued.
//  bitcnt width clog2(DW+1); no wrap ambiguity at DW=2^k.
// CONFIGURATION
//  SPI_RX_EN defined: spi_miso sampled on each clk edge that drives spi_clk 0->1,
//   shifted into rx shreg MSB first; rx_data updated in END cycle, stable until next END.
//  SPI_RX_EN undefined: no rx logic; rx_data tied to 0; spi_miso unused.
// TESTING
//  1 Reset, req=4'b0001, din0=16'hA5C3 -> gnt[0] pulse; cs_l=4'b1110 for 64 cycles;
//    MOSI bits 1010_0101_1100_0011 on spi_clk rises; done[0] 65 cycles after gnt.
//  2 req=4'b1111 held -> gnt order 0,1,2,3,0; GAP>=2 all-high cycles between frames.
//  3 ptr=1, req 0 and 3 raised in same cycle -> gnt[3] first, then gnt[0].
//  4 req[2] raised mid-frame of req 0 -> waits; gnt[2] on first IDLE cycle after GAP.
//  5 Assert reset at bit 7 of a frame -> cs_l=4'hF, spi_clk=0, busy=0 same edge; no done.
//  6 SPI_RX_EN, miso loops back MOSI, din=16'h3C5A -> rx_data=16'h3C5A at done.
//  Always: cs_l never two low; spi_clk only toggles while one cs_l low.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one mode-0, MSB-first SPI master among NREQ requesters.
// Optional receive path enabled by defining SPI_RX_EN (MISO captured into rx_data_o).

module spi_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int CLK_DIV = 2,
    parameter int GAP     = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] din_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               busy_o,
    output logic [NREQ-1:0]    spi_cs_l_o,
    output logic               spi_clk_o,
    output logic               spi_data_o,
    input  logic               spi_miso_i,
    output logic [DW-1:0]      rx_data_o
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCW = $clog2(DW + 1);
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_END  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [DW-1:0]    shreg_q;
    logic [BCW-1:0]   bitcnt_q;
    logic [DVW-1:0]   divcnt_q;
    logic [GW-1:0]    gapcnt_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             busy_q;
    logic [NREQ-1:0]  cs_l_q;
    logic             sclk_q;
    logic             mosi_q;

    logic [PW-1:0]    win_d;
    logic             found_d;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int off);
        int s;
        s = (int'(p) + off) % NREQ;
        return PW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: nearest asserted request after the previous winner.
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        win_d   = ptr_q;
        found_d = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx     = rr_idx(ptr_q, k);
            hit     = req_i[idx] & ~found_d;
            win_d   = hit ? idx : win_d;
            found_d = found_d | hit;
        end
    end

`ifdef SPI_RX_EN
    logic [DW-1:0] rx_shreg_q;
    logic [DW-1:0] rx_data_q;
    assign rx_data_o = rx_data_q;
`else
    logic unused_miso_s;
    assign unused_miso_s = spi_miso_i;
    assign rx_data_o     = '0;
`endif

    // Controller: arbitration, bit timing, frame end and inter-frame gap.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= PW'(NREQ - 1);
            shreg_q  <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            gapcnt_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cs_l_q   <= '1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
`ifdef SPI_RX_EN
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q    <= onehot(win_d);
                        cs_l_q   <= ~onehot(win_d);
                        shreg_q  <= din_i[int'(win_d)*DW +: DW];
                        mosi_q   <= din_i[int'(win_d)*DW + DW - 1];
                        busy_q   <= 1'b1;
                        ptr_q    <= win_d;
                        bitcnt_q <= BCW'(DW);
                        divcnt_q <= '0;
                        state_q  <= S_LO;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_LO: begin
                    if (divcnt_q == DIV_LAST) begin
                        sclk_q   <= 1'b1;
                        divcnt_q <= '0;
                        state_q  <= S_HI;
`ifdef SPI_RX_EN
                        rx_shreg_q <= {rx_shreg_q[DW-2:0], spi_miso_i};
`endif
                    end else begin
                        divcnt_q <= divcnt_q + DVW'(1);
                    end
                end
                S_HI: begin
                    if (divcnt_q == DIV_LAST) begin
                        sclk_q   <= 1'b0;
                        divcnt_q <= '0;
                        bitcnt_q <= bitcnt_q - BCW'(1);
                        if (bitcnt_q != BCW'(1)) begin
                            shreg_q <= shreg_q << 1;
                            mosi_q  <= shreg_q[DW-2];
                            state_q <= S_LO;
                        end else begin
                            // chip select released together with the last falling spi_clk
                            cs_l_q  <= '1;
                            mosi_q  <= 1'b0;
                            state_q <= S_END;
                        end
                    end else begin
                        divcnt_q <= divcnt_q + DVW'(1);
                    end
                end
                S_END: begin
                    done_q   <= onehot(ptr_q);
                    gapcnt_q <= '0;
                    state_q  <= S_GAP;
`ifdef SPI_RX_EN
                    rx_data_q <= rx_shreg_q;
`endif
                end
                S_GAP: begin
                    if (gapcnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gapcnt_q <= gapcnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign spi_cs_l_o = cs_l_q;
    assign spi_clk_o  = sclk_q;
    assign spi_data_o = mosi_q;

endmodule
